// File: rtl/tone_pkg.sv
// Shared types and scale constants for the pitch tone synthesizer.
package tone_pkg;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_DIVIDING = 1'b1
    } state_e;

    function automatic logic [63:0] midscale(input int w);
        return 64'd1 << (w - 1);
    endfunction

    function automatic logic [63:0] full_scale(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/phase_inc_divider.sv
// Serial restoring divider: one quotient bit per cycle, start/valid/busy handshake.
module phase_inc_divider #(
    parameter int DVD_W = 40,
    parameter int DVS_W = 13,
    parameter int Q_W   = 24
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [DVD_W-1:0] dividend_i,
    input  logic [DVS_W-1:0] divisor_i,
    output logic             busy_o,
    output logic             valid_o,
    output logic [Q_W-1:0]   quotient_o
);

    localparam int CNT_W = $clog2(DVD_W + 1);

    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DVS_W-1:0] rem_q, rem_d;
    logic [DVD_W-1:0] quo_q, quo_d;
    logic [DVS_W:0]   rem_sh;
    logic [DVS_W:0]   diff;

    // quo_q starts as the dividend; its MSBs shift into the remainder while
    // quotient bits shift in from the bottom.
    always_comb begin
        rem_sh  = {rem_q, quo_q[DVD_W-1]};
        diff    = rem_sh - {1'b0, divisor_i};
        busy_d  = busy_q;
        valid_d = 1'b0;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        if (start_i && !busy_q) begin
            busy_d = 1'b1;
            cnt_d  = CNT_W'(DVD_W);
            rem_d  = '0;
            quo_d  = dividend_i;
        end else if (busy_q) begin
            if (!diff[DVS_W]) begin
                rem_d = diff[DVS_W-1:0];
                quo_d = {quo_q[DVD_W-2:0], 1'b1};
            end else begin
                rem_d = rem_sh[DVS_W-1:0];
                quo_d = {quo_q[DVD_W-2:0], 1'b0};
            end
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                busy_d  = 1'b0;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            busy_q  <= busy_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        rem_q <= rem_d;
        quo_q <= quo_d;
    end

    assign busy_o     = busy_q;
    assign valid_o    = valid_q;
    assign quotient_o = quo_q[Q_W-1:0];

endmodule

// File: rtl/pitch_tone_synth.sv
// Phase-accumulator tone generator; square wave by default, triangle when
// TRIANGLE_WAVE_EN is defined.
module pitch_tone_synth
    import tone_pkg::*;
#(
    parameter int SIG_WIDTH   = 9,
    parameter int WIDTH       = 32,
    parameter int DEC_WIDTH   = 16,
    parameter int SAMPLE_RATE = 8000,
    parameter int CLK_FREQ    = 100_000_000,
    parameter int PHASE_WIDTH = 24,
    parameter int F_MAX       = 1000
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic [WIDTH-1:0]     f_in,
    input  logic                 f_in_valid,
    output logic                 f_in_ready,
    output logic [SIG_WIDTH-1:0] sig_out,
    output logic                 sig_out_valid
);

    localparam int TICK_DIV = CLK_FREQ / SAMPLE_RATE;
    localparam int CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SHIFT    = PHASE_WIDTH - DEC_WIDTH;
    localparam int DVD_W    = WIDTH + SHIFT;
    localparam int DVS_W    = $clog2(SAMPLE_RATE + 1);
    localparam logic [WIDTH-1:0]     F_LIM = WIDTH'(F_MAX) << DEC_WIDTH;
    localparam logic [SIG_WIDTH-1:0] MID   = SIG_WIDTH'(midscale(SIG_WIDTH));
    localparam logic [SIG_WIDTH-1:0] FULL  = SIG_WIDTH'(full_scale(SIG_WIDTH));

`ifdef TRIANGLE_WAVE_EN
    localparam int WAVE_W = SIG_WIDTH + 1;

    function automatic logic [SIG_WIDTH-1:0] wave(input logic [WAVE_W-1:0] p);
        return p[SIG_WIDTH] ? ~p[SIG_WIDTH-1:0] : p[SIG_WIDTH-1:0];
    endfunction
`else
    localparam int WAVE_W = 1;

    function automatic logic [SIG_WIDTH-1:0] wave(input logic [WAVE_W-1:0] p);
        return p[0] ? '0 : FULL;
    endfunction
`endif

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [PHASE_WIDTH-1:0] phase_q;
    logic [PHASE_WIDTH-1:0] inc_q;
    logic                   zero_q;
    logic                   pend_zero_q;
    logic [SIG_WIDTH-1:0]   sig_q;
    logic                   sig_vld_q;
    logic                   tick;
    logic                   div_start;
    logic                   div_busy;
    logic                   div_valid;
    logic [PHASE_WIDTH-1:0] div_quo;
    logic [WIDTH-1:0]       f_clamped;
    logic [DVD_W-1:0]       dividend;

    assign tick      = (cnt_q == CNT_W'(TICK_DIV - 1));
    assign f_clamped = (f_in > F_LIM) ? F_LIM : f_in;
    assign dividend  = DVD_W'(f_clamped) << SHIFT;

    always_comb begin
        state_d    = state_q;
        div_start  = 1'b0;
        f_in_ready = (state_q == ST_IDLE) && !div_busy;
        case (state_q)
            ST_IDLE: begin
                if (f_in_valid && f_in_ready) begin
                    div_start = 1'b1;
                    state_d   = ST_DIVIDING;
                end
            end
            ST_DIVIDING: begin
                if (div_valid) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    phase_inc_divider #(
        .DVD_W(DVD_W),
        .DVS_W(DVS_W),
        .Q_W  (PHASE_WIDTH)
    ) u_div (
        .clk_i     (clk_in),
        .rst_ni    (rst_in),
        .start_i   (div_start),
        .dividend_i(dividend),
        .divisor_i (DVS_W'(SAMPLE_RATE)),
        .busy_o    (div_busy),
        .valid_o   (div_valid),
        .quotient_o(div_quo)
    );

    // A tick coinciding with the inc write still samples the old inc/mode;
    // a zero-frequency write parks the phase at 0 regardless.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            phase_q     <= '0;
            inc_q       <= '0;
            zero_q      <= 1'b1;
            pend_zero_q <= 1'b0;
            sig_q       <= MID;
            sig_vld_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= tick ? '0 : cnt_q + CNT_W'(1);
            sig_vld_q <= tick;
            if (tick) sig_q <= zero_q ? MID : wave(phase_q[PHASE_WIDTH-1 -: WAVE_W]);
            if (div_start) pend_zero_q <= (f_in == '0);
            if (div_valid) begin
                inc_q  <= div_quo;
                zero_q <= pend_zero_q;
            end
            if (div_valid && pend_zero_q) phase_q <= '0;
            else if (tick)                phase_q <= phase_q + inc_q;
        end
    end

    assign sig_out       = sig_q;
    assign sig_out_valid = sig_vld_q;

endmodule

// File: tb/tb_pitch_tone_synth.sv
// Scoreboard bench for pitch_tone_synth (tick every 10 cycles); expected
// patterns follow TRIANGLE_WAVE_EN when defined.
module tb_pitch_tone_synth;

    localparam int SW = 9;
    localparam int W  = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  f_in = '0;
    logic          f_vld = 1'b0;
    logic          f_rdy;
    logic [SW-1:0] sig;
    logic          sig_vld;

    int checks = 0;
    int passes = 0;
    int exp_q[$];

`ifdef TRIANGLE_WAVE_EN
    int pat1k[8]   = '{0, 128, 256, 384, 511, 383, 255, 127};
    int pat500[16] = '{0, 64, 128, 192, 256, 320, 384, 448,
                       511, 447, 383, 319, 255, 191, 127, 63};
`else
    int pat1k[8]   = '{511, 511, 511, 511, 0, 0, 0, 0};
    int pat500[16] = '{511, 511, 511, 511, 511, 511, 511, 511,
                       0, 0, 0, 0, 0, 0, 0, 0};
`endif

    pitch_tone_synth #(
        .SIG_WIDTH  (SW),
        .WIDTH      (W),
        .DEC_WIDTH  (16),
        .SAMPLE_RATE(8000),
        .CLK_FREQ   (80000),
        .PHASE_WIDTH(24),
        .F_MAX      (1000)
    ) dut (
        .clk_in       (clk),
        .rst_in       (rst_n),
        .f_in         (f_in),
        .f_in_valid   (f_vld),
        .f_in_ready   (f_rdy),
        .sig_out      (sig),
        .sig_out_valid(sig_vld)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Monitor: every presented sample pops the next expectation, if any.
    initial begin
        int e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && sig_vld && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sample", int'(sig), e);
            end
        end
    end

    task automatic wait_ready(input int budget);
        int n = 0;
        while (!f_rdy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("ready_return", int'(f_rdy), 1);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("queue_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic program_f(input logic [W-1:0] f, input bit drop_pulse);
        @(negedge clk);
        f_in  = f;
        f_vld = 1'b1;
        @(negedge clk);
        f_vld = 1'b0;
        check("ready_low_dividing", int'(f_rdy), 0);
        if (drop_pulse) begin
            f_in  = '0;
            f_vld = 1'b1;
            repeat (3) @(negedge clk);
            check("ready_low_during_drop", int'(f_rdy), 0);
            f_vld = 1'b0;
        end
        wait_ready(200);
    endtask

    task automatic push_1k();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 8; i++) exp_q.push_back(pat1k[i]);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_sig_out", int'(sig), 256);
        check("rst_sig_valid", int'(sig_vld), 0);
        check("rst_ready", int'(f_rdy), 1);
        check("rst_inc", int'(dut.inc_q), 0);
        rst_n = 1'b1;

        repeat (2) exp_q.push_back(256);
        drain(40);

        program_f(32'h03E8_0000, 1'b1);
        check("inc_1000hz", int'(dut.inc_q), 32'h0020_0000);
        push_1k();
        drain(250);

        program_f(32'h0000_0000, 1'b0);
        repeat (4) exp_q.push_back(256);
        drain(80);

        program_f(32'h07D0_0000, 1'b0);
        check("inc_2000hz_clamped", int'(dut.inc_q), 32'h0020_0000);
        push_1k();
        drain(250);

        program_f(32'h0000_0000, 1'b0);
        program_f(32'h01F4_0000, 1'b0);
        check("inc_500hz", int'(dut.inc_q), 32'h0010_0000);
        for (int i = 0; i < 16; i++) exp_q.push_back(pat500[i]);
        drain(250);

        // Reset asserted while a 1000 Hz division is in flight.
        @(negedge clk);
        f_in  = 32'h03E8_0000;
        f_vld = 1'b1;
        @(negedge clk);
        f_vld = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_sig_out", int'(sig), 256);
        check("midrst_sig_valid", int'(sig_vld), 0);
        check("midrst_ready", int'(f_rdy), 1);
        check("midrst_phase", int'(dut.phase_q), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) exp_q.push_back(256);
        drain(60);
        check("postrst_inc", int'(dut.inc_q), 0);
        check("postrst_ready", int'(f_rdy), 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
